// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and bubble insertion.
// Latency: one cycle ID->EX; stall is combinational (zero cycles) from EX state.
// Backpressure: hold freezes every register; stall/flush turn the EX slot into a bubble.
//
// Ports:
//   clk, reset_n                 - rising-edge clock, async active-low reset
//   id_* (controls, operands)    - decoded instruction presented by the ID stage
//   flush                        - branch taken in EX, squash the instruction in ID
//   hold                         - freeze the stage while memory is busy
//   stall                        - load-use hazard, drives control unit / PC / IF-ID enables
//   ex_*                         - registered instruction fields for EX
//   ex_valid                     - EX slot holds a real instruction
//   bubble_count                 - saturating count of inserted bubbles
module id_ex_stage #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       id_ALUOp,
    input  logic             id_Branch,
    input  logic             id_MemRead,
    input  logic             id_MemtoReg,
    input  logic             id_MemWrite,
    input  logic             id_ALUSrc,
    input  logic             id_RegWrite,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic [3:0]       id_funct,
    input  logic             flush,
    input  logic             hold,
    output logic             stall,
    output logic [1:0]       ex_ALUOp,
    output logic             ex_Branch,
    output logic             ex_MemRead,
    output logic             ex_MemtoReg,
    output logic             ex_MemWrite,
    output logic             ex_ALUSrc,
    output logic             ex_RegWrite,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rs1_data,
    output logic [XLEN-1:0]  ex_rs2_data,
    output logic [XLEN-1:0]  ex_imm,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic [3:0]       ex_funct,
    output logic             ex_valid,
    output logic [CNT_W-1:0] bubble_count
);

    typedef struct packed {
        logic [1:0] alu_op;
        logic       branch;
        logic       mem_read;
        logic       mem_to_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
    } ctrl_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [3:0]      funct;
    } data_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    ctrl_t            id_ctrl;
    data_t            id_data;
    ctrl_t            ctrl_d, ctrl_q;
    data_t            data_d, data_q;
    logic             valid_d, valid_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             hazard;

    assign id_ctrl = '{alu_op: id_ALUOp, branch: id_Branch, mem_read: id_MemRead,
                       mem_to_reg: id_MemtoReg, mem_write: id_MemWrite,
                       alu_src: id_ALUSrc, reg_write: id_RegWrite};

    assign id_data = '{pc: id_pc, rs1_data: id_rs1_data, rs2_data: id_rs2_data,
                       imm: id_imm, rs1: id_rs1, rs2: id_rs2, rd: id_rd,
                       funct: id_funct};

    // rs2 is compared even for I-type encodings: a spurious stall costs one
    // cycle, a missed one corrupts architectural state.
    assign hazard = valid_q && ctrl_q.mem_read && (data_q.rd != 5'd0) &&
                    ((data_q.rd == id_rs1) || (data_q.rd == id_rs2));
    assign stall  = hazard;

    always_comb begin
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (!hold) begin
            // Datapath follows ID even for a bubble; it is ignored when valid is low.
            data_d = id_data;
            if (flush || hazard) begin
                // Controls are zeroed here even though upstream may already have
                // zeroed them, so a bubble can never write memory or registers.
                ctrl_d  = '0;
                valid_d = 1'b0;
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                ctrl_d  = id_ctrl;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ex_ALUOp     = ctrl_q.alu_op;
    assign ex_Branch    = ctrl_q.branch;
    assign ex_MemRead   = ctrl_q.mem_read;
    assign ex_MemtoReg  = ctrl_q.mem_to_reg;
    assign ex_MemWrite  = ctrl_q.mem_write;
    assign ex_ALUSrc    = ctrl_q.alu_src;
    assign ex_RegWrite  = ctrl_q.reg_write;
    assign ex_pc        = data_q.pc;
    assign ex_rs1_data  = data_q.rs1_data;
    assign ex_rs2_data  = data_q.rs2_data;
    assign ex_imm       = data_q.imm;
    assign ex_rs1       = data_q.rs1;
    assign ex_rs2       = data_q.rs2;
    assign ex_rd        = data_q.rd;
    assign ex_funct     = data_q.funct;
    assign ex_valid     = valid_q;
    assign bubble_count = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed hazard/flush/hold/reset/saturation
// sequences followed by randomized traffic, checked against a reference model.
module tb_id_ex_stage;

    localparam int XLEN  = 64;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    typedef struct {
        logic [1:0]      aluop;
        logic            branch, memread, memtoreg, memwrite, alusrc, regwrite;
        logic [XLEN-1:0] pc, rs1d, rs2d, imm;
        logic [4:0]      rs1, rs2, rd;
        logic [3:0]      funct;
    } rec_t;

    typedef struct {
        rec_t ins;
        logic flush;
        logic hold;
    } stim_t;

    typedef struct {
        rec_t r;
        logic valid;
        int   cnt;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [1:0]       id_ALUOp;
    logic             id_Branch, id_MemRead, id_MemtoReg, id_MemWrite, id_ALUSrc, id_RegWrite;
    logic [XLEN-1:0]  id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]       id_rs1, id_rs2, id_rd;
    logic [3:0]       id_funct;
    logic             flush, hold;
    logic             stall;
    logic [1:0]       ex_ALUOp;
    logic             ex_Branch, ex_MemRead, ex_MemtoReg, ex_MemWrite, ex_ALUSrc, ex_RegWrite;
    logic [XLEN-1:0]  ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]       ex_rs1, ex_rs2, ex_rd;
    logic [3:0]       ex_funct;
    logic             ex_valid;
    logic [CNT_W-1:0] bubble_count;

    id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .id_ALUOp(id_ALUOp), .id_Branch(id_Branch), .id_MemRead(id_MemRead),
        .id_MemtoReg(id_MemtoReg), .id_MemWrite(id_MemWrite), .id_ALUSrc(id_ALUSrc),
        .id_RegWrite(id_RegWrite), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
        .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_funct(id_funct), .flush(flush), .hold(hold), .stall(stall),
        .ex_ALUOp(ex_ALUOp), .ex_Branch(ex_Branch), .ex_MemRead(ex_MemRead),
        .ex_MemtoReg(ex_MemtoReg), .ex_MemWrite(ex_MemWrite), .ex_ALUSrc(ex_ALUSrc),
        .ex_RegWrite(ex_RegWrite), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
        .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_funct(ex_funct), .ex_valid(ex_valid), .bubble_count(bubble_count)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    logic stall_q[$];

    // Reference model: the instruction occupying EX, its validity, bubble tally.
    rec_t m_r;
    logic m_v;
    int   m_cnt;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic rec_t nop();
        rec_t r;
        r.aluop = 2'd0; r.branch = 0; r.memread = 0; r.memtoreg = 0;
        r.memwrite = 0; r.alusrc = 0; r.regwrite = 0;
        r.pc = '0; r.rs1d = '0; r.rs2d = '0; r.imm = '0;
        r.rs1 = 5'd0; r.rs2 = 5'd0; r.rd = 5'd0; r.funct = 4'd0;
        return r;
    endfunction

    function automatic rec_t rand_rec();
        rec_t r;
        r.aluop    = 2'($urandom_range(0, 3));
        r.branch   = 1'($urandom_range(0, 1));
        r.memread  = 1'($urandom_range(0, 1));
        r.memtoreg = 1'($urandom_range(0, 1));
        r.memwrite = 1'($urandom_range(0, 1));
        r.alusrc   = 1'($urandom_range(0, 1));
        r.regwrite = 1'($urandom_range(0, 1));
        r.pc       = {$urandom, $urandom};
        r.rs1d     = {$urandom, $urandom};
        r.rs2d     = {$urandom, $urandom};
        r.imm      = {$urandom, $urandom};
        // Small register range so load-use collisions happen often.
        r.rs1      = 5'($urandom_range(0, 7));
        r.rs2      = 5'($urandom_range(0, 7));
        r.rd       = 5'($urandom_range(0, 7));
        r.funct    = 4'($urandom_range(0, 15));
        return r;
    endfunction

    task automatic apply(input stim_t s);
        id_ALUOp = s.ins.aluop; id_Branch = s.ins.branch; id_MemRead = s.ins.memread;
        id_MemtoReg = s.ins.memtoreg; id_MemWrite = s.ins.memwrite;
        id_ALUSrc = s.ins.alusrc; id_RegWrite = s.ins.regwrite;
        id_pc = s.ins.pc; id_rs1_data = s.ins.rs1d; id_rs2_data = s.ins.rs2d;
        id_imm = s.ins.imm; id_rs1 = s.ins.rs1; id_rs2 = s.ins.rs2; id_rd = s.ins.rd;
        id_funct = s.ins.funct; flush = s.flush; hold = s.hold;
    endtask

    // One clock of stimulus: drive at the falling edge, predict, enqueue.
    task automatic cycle(input stim_t s);
        logic hz;
        exp_t e;
        @(negedge clk);
        apply(s);
        hz = m_v && m_r.memread && (m_r.rd != 0) &&
             (m_r.rd == s.ins.rs1 || m_r.rd == s.ins.rs2);
        stall_q.push_back(hz);
        if (!s.hold) begin
            m_r = s.ins;
            if (s.flush || hz) begin
                m_r.aluop = 0; m_r.branch = 0; m_r.memread = 0; m_r.memtoreg = 0;
                m_r.memwrite = 0; m_r.alusrc = 0; m_r.regwrite = 0;
                m_v = 1'b0;
                m_cnt = (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
            end else begin
                m_v = 1'b1;
            end
        end
        e.r = m_r; e.valid = m_v; e.cnt = m_cnt;
        exp_q.push_back(e);
    endtask

    task automatic instr(input rec_t r, input logic fl, input logic hd);
        stim_t s;
        s.ins = r; s.flush = fl; s.hold = hd;
        cycle(s);
    endtask

    // Freeze the DUT without predicting anything (hold keeps model and DUT aligned).
    task automatic idle();
        @(negedge clk);
        hold = 1'b1;
        flush = 1'b0;
    endtask

    task automatic check_zero(string tag);
        chk({tag, "_valid"}, ex_valid, 0);
        chk({tag, "_regwrite"}, ex_RegWrite, 0);
        chk({tag, "_ctrl"}, {ex_ALUOp, ex_Branch, ex_MemRead, ex_MemtoReg, ex_MemWrite, ex_ALUSrc}, 0);
        chk({tag, "_data"}, ex_pc | ex_rs1_data | ex_rs2_data | ex_imm, 0);
        chk({tag, "_idx"}, {ex_rs1, ex_rs2, ex_rd, ex_funct}, 0);
        chk({tag, "_count"}, bubble_count, 0);
        m_r = nop(); m_v = 1'b0; m_cnt = 0;
    endtask

    // Output monitor: one expected EX state per predicted clock edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("ex_valid", ex_valid, e.valid);
            chk("bubble_count", bubble_count, e.cnt);
            chk("ex_ctrl", {ex_ALUOp, ex_Branch, ex_MemRead, ex_MemtoReg, ex_MemWrite, ex_ALUSrc, ex_RegWrite},
                {e.r.aluop, e.r.branch, e.r.memread, e.r.memtoreg, e.r.memwrite, e.r.alusrc, e.r.regwrite});
            // Datapath is don't-care in a bubble.
            if (e.valid) begin
                chk("ex_pc", ex_pc, e.r.pc);
                chk("ex_rs1_data", ex_rs1_data, e.r.rs1d);
                chk("ex_rs2_data", ex_rs2_data, e.r.rs2d);
                chk("ex_imm", ex_imm, e.r.imm);
                chk("ex_idx", {ex_rs1, ex_rs2, ex_rd, ex_funct}, {e.r.rs1, e.r.rs2, e.r.rd, e.r.funct});
            end
        end
    end

    // Stall monitor: combinational output sampled mid-cycle after inputs settle.
    always @(negedge clk) begin
        logic s;
        #1;
        if (stall_q.size() > 0) begin
            s = stall_q.pop_front();
            chk("stall", stall, s);
        end
    end

    initial begin
        rec_t r, ld;
        stim_t s;
        m_r = nop(); m_v = 1'b0; m_cnt = 0;
        s.ins = nop(); s.flush = 1'b0; s.hold = 1'b1;
        apply(s);
        reset_n = 1'b0;
        #1;
        check_zero("reset_init");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Load-use: ld x5, then add x7,x5,x6 presented twice (re-presented after stall).
        ld = nop(); ld.memread = 1; ld.memtoreg = 1; ld.regwrite = 1; ld.alusrc = 1;
        ld.rd = 5'd5; ld.pc = 64'h100; ld.imm = 64'h8;
        instr(ld, 0, 0);
        r = nop(); r.regwrite = 1; r.aluop = 2'd2; r.rs1 = 5'd5; r.rs2 = 5'd6; r.rd = 5'd7;
        r.pc = 64'h104; r.rs1d = 64'h11; r.rs2d = 64'h22;
        instr(r, 0, 0);
        instr(r, 0, 0);

        // x0 destination never stalls; non-load producer never stalls.
        ld.rd = 5'd0;
        instr(ld, 0, 0);
        r.rs1 = 5'd0; r.rs2 = 5'd0;
        instr(r, 0, 0);
        r.rd = 5'd3;
        instr(r, 0, 0);
        r.rs1 = 5'd1; r.rs2 = 5'd3;
        instr(r, 0, 0);

        // Flush coinciding with a load-use hazard: one bubble only.
        ld.rd = 5'd9;
        instr(ld, 0, 0);
        r.rs1 = 5'd9;
        instr(r, 1, 0);
        // Flush alone squashes a store.
        r = nop(); r.memwrite = 1; r.alusrc = 1; r.rs1 = 5'd2; r.rs2 = 5'd4;
        instr(r, 1, 0);

        // Hold with a live instruction in EX: flush must not be taken while held.
        r.memwrite = 0; r.regwrite = 1;
        instr(r, 0, 0);
        for (int i = 0; i < 3; i++) instr(rand_rec(), 1, 1);
        instr(rand_rec(), 1, 0);

        // Asynchronous reset mid-stream with a RegWrite instruction in EX.
        r = nop(); r.regwrite = 1; r.rd = 5'd12; r.pc = 64'h200;
        instr(r, 0, 0);
        idle();
        @(posedge clk);
        #3;
        chk("pre_reset_valid", ex_valid, 1);
        reset_n = 1'b0;
        #1;
        check_zero("reset_mid");
        @(negedge clk);
        reset_n = 1'b1;

        // Saturation: 20 consecutive flushes.
        for (int i = 0; i < 20; i++) instr(rand_rec(), 1, 0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            s.ins   = rand_rec();
            s.flush = ($urandom_range(0, 7) == 0);
            s.hold  = ($urandom_range(0, 5) == 0);
            cycle(s);
        end

        idle();
        repeat (2) @(posedge clk);
        #2;
        chk("queues_drained", exp_q.size() + stall_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline register for the 5-stage RISC-V core, sitting directly downstream of the control unit and register-file read. It latches decoded control signals and operands into EX. It also owns the load-use hazard detector whose combinational stall output drives the control unit's stall input and the PC/IF-ID write enables. Bubble insertion covers load-use stalls and branch flushes; a hold input freezes the stage for multi-cycle memory.

Parameters:
XLEN, 64, width of PC, operand and immediate datapaths
CNT_W, 16, width of saturating bubble counter

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
id_ALUOp  input  2  ALUOp from control unit
id_Branch, id_MemRead, id_MemtoReg, id_MemWrite, id_ALUSrc, id_RegWrite  input  1 each  control from control unit
id_pc  input  XLEN  PC of instruction in ID
id_rs1_data, id_rs2_data  input  XLEN  register-file read data
id_imm  input  XLEN  sign-extended immediate
id_rs1, id_rs2, id_rd  input  5 each  register indices from IF/ID
id_funct  input  4  {instr[30], funct3} for ALU control
flush  input  1  branch taken in EX; squash instruction in ID
hold  input  1  freeze stage (memory busy)
stall  output  1  load-use hazard, combinational
ex_ALUOp  output  2  registered
ex_Branch, ex_MemRead, ex_MemtoReg, ex_MemWrite, ex_ALUSrc, ex_RegWrite  output  1 each  registered
ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  output  XLEN  registered
ex_rs1, ex_rs2, ex_rd  output  5 each  registered (rs1/rs2 for forwarding unit)
ex_funct  output  4  registered
ex_valid  output  1  EX slot holds real instruction
bubble_count  output  CNT_W  saturating count of inserted bubbles

Behaviour:
- Reset (reset_n low, async): all ex_* outputs and ex_valid = 0; bubble_count = 0. Reset released mid-operation resumes from an empty stage; no partial state is retained.
- stall = ex_valid & ex_MemRead & (ex_rd != 0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2)). Purely combinational from registered EX fields and ID indices. Conservative: rs2 is compared even for I-type.
- Per-edge update priority: reset > hold > flush > stall > normal.
  - hold=1: every register keeps its value; bubble_count unchanged; stall still computed from held state.
  - flush=1 (hold=0): bubble inserted. All control outputs = 0, ex_valid = 0. Datapath fields load ID values and are don't-care. bubble_count increments.
  - stall=1 (hold=0, flush=0): same bubble insertion; bubble_count increments. Upstream holds PC and IF/ID, so the dependent instruction re-presents next cycle. stall then deasserts because ex_MemRead = 0.
  - normal: all id_* load to ex_*, ex_valid = 1.
- Control inputs are also zeroed upstream while stall=1. The stage zeroes controls itself regardless and does not rely on that.
- flush and stall together: a single bubble is inserted and counted once.
- flush during hold is not latched. The branch unit keeps flush asserted until hold drops.
- bubble_count saturates at 2^CNT_W-1 and does not wrap.
- Latency: one cycle ID to EX; stall has zero-cycle latency from the EX state.

Test Plan:
- Reset: drive reset_n low mid-stream with ex_valid=1, ex_RegWrite=1 -> all ex_* = 0, ex_valid = 0, bubble_count = 0 immediately, without waiting for a clock edge.
- Load-use: ld x5 in EX (ex_MemRead=1, ex_rd=5), ID add with rs1=5 -> stall=1. Next edge: ex_valid=0, controls=0, bubble_count=1. Following cycle: stall=0, add latches with ex_RegWrite=1.
- x0 and no-hazard: ex_MemRead=1 with ex_rd=0 and id_rs1=0 -> stall=0. ex_MemRead=0 with ex_rd==id_rs2 -> stall=0.
- Flush+stall: flush=1 and stall=1 in the same cycle -> one bubble, bubble_count +1 only. Flush alone with id_MemWrite=1 -> ex_MemWrite=0.
- Hold: hold=1 for 3 cycles with changing id_* and flush=1 -> ex_* and bubble_count unchanged. Release hold with flush=1 -> bubble.
- Saturation: CNT_W=4, force 20 consecutive flushes -> bubble_count stops at 15.
